pc_unit: RTL and testbench

Parametrised program-counter unit, the successor of the fixed 16-bit PCL/PCH register pair with its increment/add helper. It holds the PC and executes one command per accepted cycle: increment, absolute load, low-page load, or signed relative branch. A relative branch that crosses a page takes an explicit fix-up cycle, signalled to the sequencer by a ready/valid handshake and a page-cross pulse. The CPU sequencer is the only command source; the PC drives the address-bus mux.

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_page_adder.sv | 24 ++
 rtl/pc_unit.sv | 109 ++++++++++
 tb/tb_pc_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: command codes and FSM state codes.
package pc_unit_pkg;

  localparam logic [2:0] C_PCU_NOP     = 3'd0;
  localparam logic [2:0] C_PCU_INC     = 3'd1;
  localparam logic [2:0] C_PCU_LOAD    = 3'd2;
  localparam logic [2:0] C_PCU_LOAD_LO = 3'd3;
  localparam logic [2:0] C_PCU_BRANCH  = 3'd4;

  typedef enum logic {
    S_PCU_RUN   = 1'b0,
    S_PCU_FIXUP = 1'b1
  } pcu_state_e;

endpackage

// File: rtl/pc_page_adder.sv
// In-page adder for relative branches: adds a sign-extended offset to the low PC
// part and reports whether the result left the page upward (carry) or downward (borrow).
module pc_page_adder #(
  parameter int PAGE_W = 8
) (
  input  logic [PAGE_W-1:0] pc_lo,
  input  logic [PAGE_W-1:0] off_ext,
  output logic [PAGE_W-1:0] new_lo,
  output logic              carry,
  output logic              borrow
);

  logic [PAGE_W:0] sum;
  logic            off_neg;

  // Zero-extended add of the page-width offset: the carry-out bit says whether
  // the true sum stayed inside the page, interpreted by the offset's sign.
  assign sum     = {1'b0, pc_lo} + {1'b0, off_ext};
  assign off_neg = off_ext[PAGE_W-1];
  assign new_lo  = sum[PAGE_W-1:0];
  assign carry   = ~off_neg & sum[PAGE_W];
  assign borrow  = off_neg & ~sum[PAGE_W];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: INC / LOAD / LOAD_LO / relative BRANCH with a page fix-up cycle.
// Define PC_UNIT_FAST_BRANCH_EN to resolve page-crossing branches in a single cycle.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter int                 PAGE_W   = 8,
  parameter int                 OFF_W    = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [2:0]        CMD,
  input  logic [OFF_W-1:0]  OFFSET,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_NEXT,
  output logic              PAGE_CROSS,
  output logic              BUSY
);

  localparam int PG_W = ADDR_W - PAGE_W;

  pcu_state_e        state_q, state_d;
  logic              dir_q, dir_d;        // 1: page borrow (-1), 0: page carry (+1)
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              cross_q, cross_d;

  logic [PAGE_W-1:0] off_ext;
  logic [PAGE_W-1:0] br_lo;
  logic              br_carry, br_borrow;
  logic [PG_W-1:0]   pc_pg;
  logic              accept;

  assign off_ext = PAGE_W'($signed(OFFSET));
  assign pc_pg   = pc_q[ADDR_W-1:PAGE_W];

  pc_page_adder #(.PAGE_W(PAGE_W)) u_adder (
    .pc_lo  (pc_q[PAGE_W-1:0]),
    .off_ext(off_ext),
    .new_lo (br_lo),
    .carry  (br_carry),
    .borrow (br_borrow)
  );

  // Handshake: a command transfers on any rising edge where CMD_VALID && CMD_READY;
  // CMD, OFFSET and LOAD_ADDR are only looked at in that cycle.
`ifdef PC_UNIT_FAST_BRANCH_EN
  assign CMD_READY = 1'b1;
`else
  assign CMD_READY = (state_q == S_PCU_RUN);
`endif
  assign BUSY   = ~CMD_READY;
  assign accept = CMD_VALID & CMD_READY;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pc_d    = pc_q;
    cross_d = 1'b0;
    if (state_q == S_PCU_FIXUP) begin
      pc_d[ADDR_W-1:PAGE_W] = dir_q ? (pc_pg - PG_W'(1)) : (pc_pg + PG_W'(1));
      state_d = S_PCU_RUN;
      cross_d = 1'b1;
    end else if (accept) begin
      case (CMD)
        C_PCU_INC:     pc_d = pc_q + ADDR_W'(1);
        C_PCU_LOAD:    pc_d = LOAD_ADDR;
        C_PCU_LOAD_LO: pc_d[PAGE_W-1:0] = LOAD_ADDR[PAGE_W-1:0];
        C_PCU_BRANCH: begin
          pc_d[PAGE_W-1:0] = br_lo;
`ifdef PC_UNIT_FAST_BRANCH_EN
          // Applying the page step now gives the same result as the full-width sum.
          if (br_carry)       pc_d[ADDR_W-1:PAGE_W] = pc_pg + PG_W'(1);
          else if (br_borrow) pc_d[ADDR_W-1:PAGE_W] = pc_pg - PG_W'(1);
          cross_d = br_carry | br_borrow;
`else
          if (br_carry | br_borrow) begin
            state_d = S_PCU_FIXUP;
            dir_d   = br_borrow;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= S_PCU_RUN;
      dir_q   <= 1'b0;
      pc_q    <= RESET_PC;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pc_q    <= pc_d;
      cross_q <= cross_d;
    end
  end

  assign PC         = pc_q;
  assign PC_NEXT    = pc_d;
  assign PAGE_CROSS = cross_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, increment wrap, crossing/non-crossing branches,
// FIXUP command blocking and reset during FIXUP (fast-branch variant under the macro).
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd = C_PCU_NOP;
  logic [7:0]  offset = '0;
  logic [15:0] load_addr = '0;
  logic [15:0] pc, pc_next;
  logic        page_cross, busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  pc_unit #(.ADDR_W(16), .PAGE_W(8), .OFF_W(8), .RESET_PC(16'h0000)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD       (cmd),
    .OFFSET    (offset),
    .LOAD_ADDR (load_addr),
    .PC        (pc),
    .PC_NEXT   (pc_next),
    .PAGE_CROSS(page_cross),
    .BUSY      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // Drive one cycle's inputs on the falling edge, return just after the rising edge.
  task automatic cyc(input logic res, input logic vld, input logic [2:0] c,
                     input logic [7:0] off, input logic [15:0] addr);
    @(negedge CLK);
    RES = res; cmd_valid = vld; cmd = c; offset = off; load_addr = addr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, C_PCU_NOP, 8'h00, 16'h0000);
  endtask

  task automatic load(input logic [15:0] addr);
    cyc(1'b0, 1'b1, C_PCU_LOAD, 8'h00, addr);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, pc, e);
    end
  endtask

  initial begin
    // 1. reset then INC x3
    cyc(1'b1, 1'b0, C_PCU_NOP, 8'h00, 16'h0000);
    cyc(1'b1, 1'b0, C_PCU_NOP, 8'h00, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_cross", page_cross, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(16'(i));
      cyc(1'b0, 1'b1, C_PCU_INC, 8'h00, 16'h0000);
      check("inc_ready", cmd_ready, 1'b1);
      pop_check("inc_pc");
    end

    // 2. INC page carry and full wrap
    load(16'h12FF);
    check("load_12ff", pc, 16'h12FF);
    cyc(1'b0, 1'b1, C_PCU_INC, 8'h00, 16'h0000);
    check("inc_carry_pc", pc, 16'h1300);
    check("inc_carry_ready", cmd_ready, 1'b1);
    idle();
    check("inc_carry_nocross", page_cross, 1'b0);
    load(16'hFFFF);
    cyc(1'b0, 1'b1, C_PCU_INC, 8'h00, 16'h0000);
    check("inc_wrap_pc", pc, 16'h0000);

`ifndef PC_UNIT_FAST_BRANCH_EN
    // 3. forward crossing branch
    load(16'h10F0);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'h20, 16'h0000);
    check("fwd_pc_lo", pc, 16'h1010);
    check("fwd_busy", busy, 1'b1);
    check("fwd_ready_low", cmd_ready, 1'b0);
    check("fwd_pc_next", pc_next, 16'h1110);
    idle();
    check("fwd_pc_fix", pc, 16'h1110);
    check("fwd_cross", page_cross, 1'b1);
    check("fwd_ready", cmd_ready, 1'b1);
    idle();
    check("fwd_cross_pulse_end", page_cross, 1'b0);

    // 4. backward crossing with page wrap; LOAD held during FIXUP
    load(16'h0005);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'hF0, 16'h0000);
    check("bwd_pc_lo", pc, 16'h00F5);
    check("bwd_busy", busy, 1'b1);
    cyc(1'b0, 1'b1, C_PCU_LOAD, 8'h00, 16'hAAAA);
    check("bwd_pc_fix", pc, 16'hFFF5);
    check("bwd_cross", page_cross, 1'b1);
    cyc(1'b0, 1'b1, C_PCU_LOAD, 8'h00, 16'hAAAA);
    check("bwd_load_after", pc, 16'hAAAA);
    check("bwd_cross_clear", page_cross, 1'b0);
`endif

    // 5. non-crossing branch, LOAD_LO, unused code
    load(16'h2040);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'h10, 16'h0000);
    check("nocross_pc", pc, 16'h2050);
    check("nocross_busy", busy, 1'b0);
    check("nocross_cross", page_cross, 1'b0);
    cyc(1'b0, 1'b1, C_PCU_LOAD_LO, 8'h00, 16'hBEEF);
    check("load_lo_pc", pc, 16'h20EF);
    cyc(1'b0, 1'b1, 3'd5, 8'h33, 16'h1234);
    check("code5_nop", pc, 16'h20EF);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'hF0, 16'h0000);
    check("nocross_neg_pc", pc, 16'h20DF);
    check("nocross_neg_busy", busy, 1'b0);

`ifndef PC_UNIT_FAST_BRANCH_EN
    // 6. reset during FIXUP
    load(16'h10F0);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'h20, 16'h0000);
    check("rstfix_busy", busy, 1'b1);
    cyc(1'b1, 1'b0, C_PCU_NOP, 8'h00, 16'h0000);
    check("rstfix_pc", pc, 16'h0000);
    check("rstfix_busy_clr", busy, 1'b0);
    check("rstfix_cross", page_cross, 1'b0);
    idle();
    check("rstfix_cross_after", page_cross, 1'b0);
    check("rstfix_pc_hold", pc, 16'h0000);
`else
    // 6. fast branch: crossing resolved in one cycle
    load(16'h10F0);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'h20, 16'h0000);
    check("fast_fwd_pc", pc, 16'h1110);
    check("fast_fwd_busy", busy, 1'b0);
    check("fast_fwd_cross", page_cross, 1'b1);
    load(16'h0005);
    check("fast_cross_end", page_cross, 1'b0);
    cyc(1'b0, 1'b1, C_PCU_BRANCH, 8'hF0, 16'h0000);
    check("fast_bwd_pc", pc, 16'hFFF5);
    check("fast_bwd_busy", busy, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
